psum_accum_ctrl: RTL and testbench
==================================

// Module: psum_accum_ctrl
// PURPOSE
//  Read-modify-write controller driving the write port of memory_s. Accepts partial-sum
//  beats (slice, address, 24-bit signed value), reads the old word back through wrout,
//  adds with signed saturation, writes the result. Also bulk-clears one 40-entry slice.
//  Sits directly upstream of memory_s: its wraddr/wrslc/in/wren are driven from here.
// PARAMETERS
//  DW      24  data width (signed two's complement)
//  DEPTH   40  entries per slice; addr >= DEPTH is illegal
//  RD_LAT  1   cycles from address presented (wren=0) to wrout valid; legal 1..3
// PORTS
//  clk       in   1   single clock, rising edge
//  rst_n     in   1   reset, asynchronous assert, active low
//  in_valid  in   1   accumulate beat valid
//  in_ready  out  1   beat accepted when in_valid && in_ready
//  in_addr   in   6   entry within slice
//  in_slc    in   2   slice 0..2; 3 illegal
//  in_data   in   DW  signed addend
//  in_first  in   1   1 = overwrite entry with in_data (no read)
//  clr_req   in   1   start bulk clear of clr_slc
//  clr_slc   in   2   slice to clear
//  flag_clr  in   1   clears sat_flag and err_flag
//  wraddr    out  6   to memory_s wraddr
//  wrslc     out  2   to memory_s wrslc
//  wrdata    out  DW  to memory_s in
//  wren      out  1   to memory_s wren
//  wrout     in   DW  from memory_s wrout (old word)
//  busy      out  1   state != IDLE
//  sat_flag  out  1   sticky: a sum saturated
//  err_flag  out  1   sticky: illegal addr/slice seen
//  wr_cnt    out  16  completed accumulate writes, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: all outputs 0 except in_ready=1; state IDLE; async assert aborts any op,
//    no wren pulse after reset asserts; a half-done RMW is lost.
//  - All memory-side outputs registered. in_ready=1 only in IDLE.
//  - States: IDLE, RD, CAP, WR, CLR.
//  - IDLE: clr_req has priority over in_valid in the same cycle (in_ready then drops
//    next cycle; beat not taken). Legal beat latched; in_first ? WR : RD.
//  - RD: wraddr/wrslc = latched op, wren=0, held RD_LAT cycles -> CAP.
//  - CAP: wrout valid; sum = sat(wrout + data) registered -> WR.
//  - WR: wren=1 one cycle, wrdata = sum (or in_data if in_first); wr_cnt++ -> IDLE.
//  - Op cost: RMW = RD_LAT+3 cycles incl. accept; first-beat = 2 cycles.
//  - Add: 25-bit signed sum; > 0x7FFFFF -> 0x7FFFFF, < -0x800000 -> 0x800000; sets sat_flag.
//  - Illegal beat (addr >= DEPTH or slc==3): accepted, dropped, no memory activity,
//    err_flag set, stays IDLE. clr_req with clr_slc==3: ignored, err_flag set.
//  - CLR: wrslc=clr_slc, wraddr 0..DEPTH-1 one per cycle, wren=1, wrdata=0; 40 cycles,
//    then IDLE. wr_cnt not incremented. in_valid ignored while busy.
//  - flag_clr and a new set event in the same cycle: set wins.
//  - Serialised ops: no same-address hazard exists; no forwarding required.
// STRUCTURE
//  - Shared package psum_pkg: DW, DEPTH, AW=6, SLC_W=2, slice offsets 0/40/80,
//    state enum {IDLE,RD,CAP,WR,CLR}, SAT_MAX/SAT_MIN constants.
//  - One sub-module: sat_add (combinational DW-bit signed saturating adder + sat flag).
//  - Top: FSM, RD_LAT counter, clear address counter, op latch, flags, wr_cnt.
// TESTING (RD_LAT=1, memory_s model attached)
//  - Beat slc1 addr5 data 100 first=1, then slc1 addr5 data -30 -> entry 45 holds 70,
//    wren seen twice, wr_cnt=2, accumulate beat takes 4 cycles accept-to-accept.
//  - Entry 0x7FFFF0 + 0x20 -> 0x7FFFFF, sat_flag=1; flag_clr -> 0; entry -0x800000 + -1
//    -> 0x800000, sat_flag=1.
//  - Beat addr 40 slc0, then slc 3 addr 0 -> no wren, err_flag=1, memory unchanged.
//  - clr_req slc2 with in_valid high same cycle -> 40 writes of 0 at addr 80..119,
//    busy 40 cycles, then beat accepted; clr_req slc3 -> ignored, err_flag=1.
//  - rst_n low during RD -> outputs 0, in_ready=1, no write at that address.
//  - Random legal beat stream with random in_valid gaps vs. scoreboard; RD_LAT=2,3 reruns.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum accumulate controller.
//   DW / DEPTH / AW / SLC_W : data width, entries per slice, address and slice widths
//   SLCx_OFS                : flat offset of each slice inside memory_s
//   ST_*                    : controller states (state_t)
//   SAT_MAX / SAT_MIN       : saturation limits of the signed accumulator
package psum_pkg;

    localparam int DW    = 24;
    localparam int DEPTH = 40;
    localparam int AW    = 6;
    localparam int SLC_W = 2;

    localparam int SLC0_OFS = 0;
    localparam int SLC1_OFS = 40;
    localparam int SLC2_OFS = 80;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD   = 3'd1;
    localparam state_t ST_CAP  = 3'd2;
    localparam state_t ST_WR   = 3'd3;
    localparam state_t ST_CLR  = 3'd4;

    localparam logic [DW-1:0] SAT_MAX = 24'h7FFFFF;
    localparam logic [DW-1:0] SAT_MIN = 24'h800000;

endpackage

// File: rtl/psum_accum_ctrl_sat_add.sv
// Combinational signed saturating adder.
//   a, b : DW-bit two's complement operands
//   sum  : a + b clamped to [SAT_MIN, SAT_MAX]
//   sat  : 1 when clamping happened
module psum_accum_ctrl_sat_add
    import psum_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum,
    output logic          sat
);

    logic [DW:0] full;

    always_comb begin
        full = {a[DW-1], a} + {b[DW-1], b};
        // Overflow iff the extra sign bit disagrees with the result sign bit;
        // the extra bit then tells which rail was crossed.
        sat = full[DW] ^ full[DW-1];
        if (!sat) begin
            sum = full[DW-1:0];
        end else if (full[DW]) begin
            sum = SAT_MIN;
        end else begin
            sum = SAT_MAX;
        end
    end

endmodule

// File: rtl/psum_accum_ctrl.sv
// Read-modify-write controller for the write port of memory_s.
// Accepts partial-sum beats, reads the old word back, adds with signed
// saturation and writes the result; also bulk-clears one slice.
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready          : beat handshake; in_addr/in_slc/in_data/in_first beat payload
//   clr_req/clr_slc            : start a bulk clear of one slice
//   flag_clr                   : clear sat_flag and err_flag
//   wraddr/wrslc/wrdata/wren   : registered memory_s write-port drive
//   wrout                      : old word from memory_s, valid RD_LAT cycles after address
//   busy, sat_flag, err_flag, wr_cnt : status
module psum_accum_ctrl
    import psum_pkg::*;
#(
    parameter int RD_LAT = 1   // 1..3
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    in_addr,
    input  logic [SLC_W-1:0] in_slc,
    input  logic [DW-1:0]    in_data,
    input  logic             in_first,
    input  logic             clr_req,
    input  logic [SLC_W-1:0] clr_slc,
    input  logic             flag_clr,
    output logic [AW-1:0]    wraddr,
    output logic [SLC_W-1:0] wrslc,
    output logic [DW-1:0]    wrdata,
    output logic             wren,
    input  logic [DW-1:0]    wrout,
    output logic             busy,
    output logic             sat_flag,
    output logic             err_flag,
    output logic [15:0]      wr_cnt
);

    localparam logic [1:0]    RD_LAST   = 2'(RD_LAT - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);

    state_t            state_reg,    state_next;
    logic [1:0]        rd_cnt_reg,   rd_cnt_next;
    logic [DW-1:0]     op_data_reg,  op_data_next;
    logic [AW-1:0]     wraddr_reg,   wraddr_next;
    logic [SLC_W-1:0]  wrslc_reg,    wrslc_next;
    logic [DW-1:0]     wrdata_reg,   wrdata_next;
    logic              wren_reg,     wren_next;
    logic              in_ready_reg, in_ready_next;
    logic              sat_reg,      sat_next;
    logic              err_reg,      err_next;
    logic [15:0]       wr_cnt_reg,   wr_cnt_next;

    logic              beat_legal;
    logic              clr_legal;
    logic              sat_set;
    logic              err_set;
    logic [DW-1:0]     sum_sat;
    logic              sum_ovf;

    assign beat_legal = (in_addr < DEPTH_A) && (in_slc != 2'd3);
    assign clr_legal  = (clr_slc != 2'd3);

    // wrout is only meaningful in CAP; the adder output is consumed there alone.
    psum_accum_ctrl_sat_add u_sat_add (
        .a   (wrout),
        .b   (op_data_reg),
        .sum (sum_sat),
        .sat (sum_ovf)
    );

    always_comb begin
        state_next   = state_reg;
        rd_cnt_next  = rd_cnt_reg;
        op_data_next = op_data_reg;
        wraddr_next  = wraddr_reg;
        wrslc_next   = wrslc_reg;
        wrdata_next  = wrdata_reg;
        wren_next    = wren_reg;
        wr_cnt_next  = wr_cnt_reg;
        sat_set      = 1'b0;
        err_set      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // A clear request wins over a beat presented in the same cycle.
                if (clr_req) begin
                    if (clr_legal) begin
                        state_next  = ST_CLR;
                        wrslc_next  = clr_slc;
                        wraddr_next = '0;
                        wrdata_next = '0;
                        wren_next   = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (in_valid) begin
                    if (beat_legal) begin
                        wraddr_next  = in_addr;
                        wrslc_next   = in_slc;
                        op_data_next = in_data;
                        rd_cnt_next  = '0;
                        if (in_first) begin
                            state_next  = ST_WR;
                            wrdata_next = in_data;
                            wren_next   = 1'b1;
                        end else begin
                            state_next  = ST_RD;
                        end
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_RD: begin
                if (rd_cnt_reg == RD_LAST) begin
                    state_next = ST_CAP;
                end else begin
                    rd_cnt_next = rd_cnt_reg + 2'd1;
                end
            end
            ST_CAP: begin
                wrdata_next = sum_sat;
                wren_next   = 1'b1;
                sat_set     = sum_ovf;
                state_next  = ST_WR;
            end
            ST_WR: begin
                wren_next   = 1'b0;
                wr_cnt_next = wr_cnt_reg + 16'd1;
                state_next  = ST_IDLE;
            end
            ST_CLR: begin
                if (wraddr_reg == LAST_ADDR) begin
                    wren_next  = 1'b0;
                    state_next = ST_IDLE;
                end else begin
                    wraddr_next = wraddr_reg + AW'(1);
                end
            end
            default: begin
                wren_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase

        in_ready_next = (state_next == ST_IDLE);
        // A set event in the same cycle as flag_clr takes precedence.
        sat_next = sat_set | (sat_reg & ~flag_clr);
        err_next = err_set | (err_reg & ~flag_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rd_cnt_reg   <= '0;
            op_data_reg  <= '0;
            wraddr_reg   <= '0;
            wrslc_reg    <= '0;
            wrdata_reg   <= '0;
            wren_reg     <= 1'b0;
            in_ready_reg <= 1'b1;
            sat_reg      <= 1'b0;
            err_reg      <= 1'b0;
            wr_cnt_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            rd_cnt_reg   <= rd_cnt_next;
            op_data_reg  <= op_data_next;
            wraddr_reg   <= wraddr_next;
            wrslc_reg    <= wrslc_next;
            wrdata_reg   <= wrdata_next;
            wren_reg     <= wren_next;
            in_ready_reg <= in_ready_next;
            sat_reg      <= sat_next;
            err_reg      <= err_next;
            wr_cnt_reg   <= wr_cnt_next;
        end
    end

    assign in_ready = in_ready_reg;
    assign wraddr   = wraddr_reg;
    assign wrslc    = wrslc_reg;
    assign wrdata   = wrdata_reg;
    assign wren     = wren_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign sat_flag = sat_reg;
    assign err_flag = err_reg;
    assign wr_cnt   = wr_cnt_reg;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Testbench for psum_accum_ctrl with a behavioural memory_s attached.
module tb_psum_accum_ctrl;
    import psum_pkg::*;

    parameter int RD_LAT = 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    in_addr;
    logic [SLC_W-1:0] in_slc;
    logic [DW-1:0]    in_data;
    logic             in_first;
    logic             clr_req;
    logic [SLC_W-1:0] clr_slc;
    logic             flag_clr;
    logic [AW-1:0]    wraddr;
    logic [SLC_W-1:0] wrslc;
    logic [DW-1:0]    wrdata;
    logic             wren;
    logic [DW-1:0]    wrout;
    logic             busy;
    logic             sat_flag;
    logic             err_flag;
    logic [15:0]      wr_cnt;

    psum_accum_ctrl #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_slc(in_slc),
        .in_data(in_data), .in_first(in_first),
        .clr_req(clr_req), .clr_slc(clr_slc), .flag_clr(flag_clr),
        .wraddr(wraddr), .wrslc(wrslc), .wrdata(wrdata), .wren(wren), .wrout(wrout),
        .busy(busy), .sat_flag(sat_flag), .err_flag(err_flag), .wr_cnt(wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory_s model ----------------
    logic [DW-1:0] mem [0:119];
    logic [DW-1:0] rd_pipe [0:2];
    logic          init_mem;
    int            mem_idx;

    assign mem_idx = int'(wrslc) * DEPTH + int'(wraddr);
    assign wrout   = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 120; i++) mem[i] <= '0;
        end else if (wren && mem_idx < 120) begin
            mem[mem_idx] <= wrdata;
        end
        rd_pipe[0] <= (mem_idx < 120) ? mem[mem_idx] : '0;
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int idx;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  ref_mem [0:119];
    int  n_checks = 0;
    int  n_errors = 0;
    int  exp_wr_cnt = 0;
    bit  exp_sat = 0;
    bit  exp_err = 0;
    int  cyc = 0;
    int  busy_cnt = 0;
    int  n_wren = 0;
    int  accept_cyc = 0;
    wr_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    function automatic int sat24(input int s);
        if (s > 8388607)  return 8388607;
        if (s < -8388608) return -8388608;
        return s;
    endfunction

    // Monitor: every write the DUT presents must match the next expected write.
    always @(negedge clk) begin
        if (rst_n && wren) begin
            n_wren++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: idx %0d data %0d, expected no write",
                         mem_idx, int'($signed(wrdata)));
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_idx", mem_idx, mon_e.idx);
                chk("wr_data", int'($signed(wrdata)), mon_e.data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_beat(input int slc, input int addr, input int data, input bit first);
        int to;
        int idx;
        int val;
        int raw;
        @(negedge clk);
        in_valid = 1'b1;
        in_slc   = slc[1:0];
        in_addr  = addr[5:0];
        in_data  = data[23:0];
        in_first = first;
        to = 0;
        while (!(in_ready && !clr_req)) begin
            @(negedge clk);
            to++;
            if (to > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_timeout: beat slc %0d addr %0d not accepted in 200 cycles", slc, addr);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
        if (addr < DEPTH && slc < 3) begin
            idx = slc * DEPTH + addr;
            raw = ref_mem[idx] + data;
            val = first ? data : sat24(raw);
            if (!first && raw != val) exp_sat = 1'b1;
            ref_mem[idx] = val;
            exp_q.push_back('{idx, val});
            exp_wr_cnt++;
        end else begin
            exp_err = 1'b1;
        end
        $display("beat slc %0d addr %0d data %0d first %0d accepted at cycle %0d",
                 slc, addr, data, first, accept_cyc);
    endtask

    task automatic wait_idle();
        int to;
        to = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && to < 300) begin
            @(negedge clk);
            to++;
        end
        if (to >= 300) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: busy %0d pending %0d after 300 cycles", busy, exp_q.size());
        end
    endtask

    task automatic pulse_flag_clr();
        @(negedge clk);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        exp_sat = 1'b0;
        exp_err = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c1, c2, c3, c0, b0, w0, mism, sz;
        int slc, addr, data;
        bit first;

        rst_n = 1'b0; init_mem = 1'b1;
        in_valid = 0; in_addr = 0; in_slc = 0; in_data = 0; in_first = 0;
        clr_req = 0; clr_slc = 0; flag_clr = 0;
        for (int i = 0; i < 120; i++) ref_mem[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_wren", int'(wren), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_flags", int'({sat_flag, err_flag}), 0);
        chk("rst_wr_cnt", int'(wr_cnt), 0);
        chk("rst_wrdata", int'(wrdata), 0);
        init_mem = 1'b0;
        rst_n = 1'b1;

        // first-beat overwrite then accumulate into slice1 entry 5 (flat 45)
        send_beat(1, 5, 100, 1);  c1 = accept_cyc;
        send_beat(1, 5, -30, 0);  c2 = accept_cyc;
        send_beat(0, 7, 11, 1);   c3 = accept_cyc;
        chk("first_beat_cycles", c2 - c1, 2);
        chk("rmw_beat_cycles", c3 - c2, RD_LAT + 3);
        wait_idle();
        chk("entry45", int'($signed(mem[45])), 70);
        chk("wren_count", n_wren, 3);
        chk("wr_cnt_3", int'(wr_cnt), 3);

        // positive and negative saturation
        send_beat(2, 0, 'h7FFFF0, 1);
        send_beat(2, 0, 'h20, 0);
        wait_idle();
        chk("sat_pos_val", int'(mem[80]), 'h7FFFFF);
        chk("sat_pos_flag", int'(sat_flag), 1);
        pulse_flag_clr();
        chk("sat_cleared", int'(sat_flag), 0);
        send_beat(2, 1, -8388608, 1);
        send_beat(2, 1, -1, 0);
        wait_idle();
        chk("sat_neg_val", int'(mem[81]), 'h800000);
        chk("sat_neg_flag", int'(sat_flag), 1);

        // illegal beats: accepted back-to-back, no memory activity
        pulse_flag_clr();
        chk("err_cleared", int'(err_flag), 0);
        w0 = n_wren;
        send_beat(0, 40, 5, 0);  c1 = accept_cyc;
        send_beat(3, 0, 5, 1);   c2 = accept_cyc;
        repeat (4) @(negedge clk);
        chk("illegal_cycles", c2 - c1, 1);
        chk("illegal_err", int'(err_flag), 1);
        chk("illegal_no_wren", n_wren - w0, 0);
        chk("illegal_busy", int'(busy), 0);

        // clear slice 2 while a beat waits; clear wins
        pulse_flag_clr();
        @(negedge clk);
        clr_req = 1'b1; clr_slc = 2'd2;
        in_valid = 1'b1; in_slc = 2'd0; in_addr = 6'd3; in_data = 24'd9; in_first = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back('{80 + i, 0});
            ref_mem[80 + i] = 0;
        end
        @(posedge clk);
        #1;
        c0 = cyc;
        b0 = busy_cnt;
        $display("clear slc 2 accepted at cycle %0d", c0);
        @(negedge clk);
        clr_req = 1'b0;
        chk("clr_in_ready_drop", int'(in_ready), 0);
        send_beat(0, 3, 9, 1);
        chk("clr_to_beat_cycles", accept_cyc - c0, DEPTH + 1);
        chk("clr_busy_cycles", busy_cnt - b0, DEPTH);
        wait_idle();
        chk("clr_entry80", int'(mem[80]), 0);
        chk("clr_entry119", int'(mem[119]), 0);
        chk("clr_no_err", int'(err_flag), 0);

        @(negedge clk);
        clr_req = 1'b1; clr_slc = 2'd3;
        @(negedge clk);
        clr_req = 1'b0;
        exp_err = 1'b1;
        $display("clear slc 3 issued");
        chk("clr3_busy", int'(busy), 0);
        chk("clr3_err", int'(err_flag), 1);

        // reset in the middle of a read-modify-write
        send_beat(1, 5, 7, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstrd_wren", int'(wren), 0);
        chk("rstrd_in_ready", int'(in_ready), 1);
        chk("rstrd_busy", int'(busy), 0);
        chk("rstrd_wraddr", int'(wraddr), 0);
        chk("rstrd_flags", int'({sat_flag, err_flag}), 0);
        void'(exp_q.pop_back());
        ref_mem[45] = 70;
        exp_wr_cnt = 0; exp_sat = 0; exp_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rstrd_entry45", int'($signed(mem[45])), 70);
        chk("rstrd_wr_cnt", int'(wr_cnt), 0);

        // random legal stream with gaps
        for (int n = 0; n < 60; n++) begin
            slc   = int'($urandom_range(0, 2));
            addr  = int'($urandom_range(0, DEPTH - 1));
            first = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0)
                data = ($urandom_range(0, 1) == 1) ? 'h700000 : -'h700000;
            else
                data = int'($urandom_range(0, 2000)) - 1000;
            send_beat(slc, addr, data, first);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        chk("rand_sat_flag", int'(sat_flag), int'(exp_sat));
        chk("rand_err_flag", int'(err_flag), 0);
        chk("rand_wr_cnt", int'(wr_cnt), exp_wr_cnt);

        mism = 0;
        for (int i = 0; i < 120; i++)
            if (int'($signed(mem[i])) != ref_mem[i]) mism++;
        chk("mem_final_mismatches", mism, 0);
        sz = exp_q.size();
        chk("pending_writes", sz, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

endmodule
